// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 LSB first with back-to-back frames.
// Define UART_TX_PARITY_EN for 8E1 (even parity bit between data and stop).
module uart_tx_fifo #(
    parameter int BAUDRATE = 3_000_000,
    parameter int CLKFREQ  = 100_000_000,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [7:0]               din,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int BC = CLKFREQ / BAUDRATE - 1;
    localparam int BW = BC > 0 ? $clog2(BC + 1) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [BW-1:0] BAUD_END = BW'(BC);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    logic par;
`endif
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [2:0]    state, bitn;
    logic [BW-1:0] cnt;
    logic [7:0]    shift;
    logic          tick, push, pop;

    assign tick  = cnt == BAUD_END;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign busy  = state != IDLE;
    assign push  = wr && !full;
    // Popping at the end of STOP chains the next frame with no idle gap.
    assign pop   = !empty && (state == IDLE || (state == STOP && tick));

    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= wp + AW'(push);
            rp       <= rp + AW'(pop);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= wr && full;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (pop) begin
            state <= START;
            tx    <= 1'b0;
            cnt   <= '0;
            shift <= mem[rp];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rp];
`endif
        end else if (state != IDLE) begin
            cnt <= tick ? '0 : cnt + BW'(1);
            if (tick)
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                        bitn  <= '0;
                    end
                    DATA:
                        if (bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            shift <= shift >> 1;
                            tx    <= shift[1];
                            bitn  <= bitn + 3'd1;
                        end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
        end
endmodule
